// File: rtl/pwm_multi_channel_if.sv
// -----------------------------------------------------------------------------
// pwm_multi_channel_if
//
// Bundles the control, duty-write and output signals of the multi-channel PWM
// generator. The register file side drives through the master modport and the
// PWM core receives through the slave modport.
//
// Signals:
//   en_out       per-channel output enable
//   en_pwm       per-channel PWM enable (0 = static high while en_out=1)
//   duty_wr_en   one-cycle duty write strobe
//   duty_wr_ch   target channel of the duty write
//   duty_wr_data new duty value
//   prescale     counter advances once every prescale+1 clk cycles
//   center_mode  0 = edge-aligned, 1 = center-aligned (taken at period boundary)
//   period_start one-cycle pulse on each period boundary
//   out          registered channel outputs
// -----------------------------------------------------------------------------
interface pwm_multi_channel_if #(
   parameter int NUM_CH  = 16,
   parameter int CNT_W   = 8,
   parameter int PRESC_W = 4
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0]  en_out;
   logic [NUM_CH-1:0]  en_pwm;
   logic               duty_wr_en;
   logic [CH_W-1:0]    duty_wr_ch;
   logic [CNT_W-1:0]   duty_wr_data;
   logic [PRESC_W-1:0] prescale;
   logic               center_mode;
   logic               period_start;
   logic [NUM_CH-1:0]  out;

   modport master (
      output en_out, en_pwm, duty_wr_en, duty_wr_ch, duty_wr_data,
             prescale, center_mode,
      input  period_start, out
   );

   modport slave (
      input  en_out, en_pwm, duty_wr_en, duty_wr_ch, duty_wr_data,
             prescale, center_mode,
      output period_start, out
   );
endinterface

// File: rtl/pwm_multi_channel.sv
// -----------------------------------------------------------------------------
// pwm_multi_channel
//
// Multi-channel PWM generator with a shared prescaled counter, per-channel
// double-buffered duty values and edge- or center-aligned operation. Duty
// writes land in a pending buffer and are promoted to the active buffer only at
// a period boundary, so a period is never cut short or stretched by an update.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    pwm_multi_channel_if.slave (controls in, period_start/out out)
// -----------------------------------------------------------------------------
module pwm_multi_channel #(
   parameter int NUM_CH  = 16,
   parameter int CNT_W   = 8,
   parameter int PRESC_W = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   pwm_multi_channel_if.slave        bus
);

   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [CNT_W-1:0]   MAX       = '1;
   localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
   localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);
   // One bit wider than the index so NUM_CH itself is representable.
   localparam logic [CH_W:0]      NUM_CH_L  = (CH_W+1)'(NUM_CH);

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   typedef logic [CNT_W-1:0] duty_arr_t [NUM_CH];

   // State
   logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
   logic [CNT_W-1:0]   cnt_q,       cnt_d;
   dir_e               dir_q,       dir_d;
   logic               mode_act_q,  mode_act_d;
   duty_arr_t          duty_pend_q, duty_pend_d;
   duty_arr_t          duty_act_q,  duty_act_d;
   logic               period_start_q;
   logic [NUM_CH-1:0]  out_q,       out_d;

   // Combinational helpers
   logic               tick;
   logic               boundary;
   logic               wr_valid;
   logic [NUM_CH-1:0]  pwm_raw;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_cnt_q    <= '0;
         cnt_q          <= '0;
         dir_q          <= DIR_UP;
         mode_act_q     <= 1'b0;
         // NOTE: the duty buffers are a small flop array, not a RAM, so they
         // are cleared with everything else; after reset every channel idles
         // at duty 0.
         duty_pend_q    <= '{default: '0};
         duty_act_q     <= '{default: '0};
         period_start_q <= 1'b0;
         out_q          <= '0;
      end else begin
         presc_cnt_q    <= presc_cnt_d;
         cnt_q          <= cnt_d;
         dir_q          <= dir_d;
         mode_act_q     <= mode_act_d;
         duty_pend_q    <= duty_pend_d;
         duty_act_q     <= duty_act_d;
         period_start_q <= boundary;
         out_q          <= out_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: every variable gets a default before any branch so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      presc_cnt_d = presc_cnt_q;
      cnt_d       = cnt_q;
      dir_d       = dir_q;
      mode_act_d  = mode_act_q;
      duty_pend_d = duty_pend_q;
      duty_act_d  = duty_act_q;

      // ">=" rather than "==" so lowering prescale below the running count
      // produces an immediate tick instead of a wrap-around stall.
      tick     = (presc_cnt_q >= bus.prescale);
      boundary = tick && (mode_act_q ? ((cnt_q == CNT_ONE) && (dir_q == DIR_DOWN))
                                     : (cnt_q == MAX));
      wr_valid = bus.duty_wr_en && ({1'b0, bus.duty_wr_ch} < NUM_CH_L);

      presc_cnt_d = tick ? '0 : presc_cnt_q + PRESC_ONE;

      if (boundary) begin
         // New period: restart the ramp upward, latch mode and duties.
         cnt_d      = '0;
         dir_d      = DIR_UP;
         mode_act_d = bus.center_mode;
         duty_act_d = duty_pend_q;
      end else if (tick) begin
         if (!mode_act_q) begin
            cnt_d = cnt_q + CNT_ONE;
         end else if (dir_q == DIR_UP) begin
            if (cnt_q == MAX) begin
               cnt_d = MAX - CNT_ONE;
               dir_d = DIR_DOWN;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end else begin
            if (cnt_q == '0) begin
               cnt_d = CNT_ONE;
               dir_d = DIR_UP;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
      end

      // A write landing on a boundary goes straight into the active buffer as
      // well, overriding whatever was pending for that channel.
      if (wr_valid) begin
         duty_pend_d[bus.duty_wr_ch] = bus.duty_wr_data;
         if (boundary) begin
            duty_act_d[bus.duty_wr_ch] = bus.duty_wr_data;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      pwm_raw = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         // duty == MAX is forced high so full scale really means 100 %.
         pwm_raw[i] = (duty_act_q[i] == MAX) || (cnt_q < duty_act_q[i]);
      end
      out_d = bus.en_out & (~bus.en_pwm | pwm_raw);
   end

   assign bus.period_start = period_start_q;
   assign bus.out          = out_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// -----------------------------------------------------------------------------
// tb_pwm_multi_channel
//
// Main instance: NUM_CH=16, CNT_W=8, PRESC_W=4, followed every cycle by a
// behavioural model that tracks the position inside the current period.
// Second instance: NUM_CH=5, CNT_W=4 so that out-of-range channel indices
// (5..7) can be driven on a 3-bit write index.
// -----------------------------------------------------------------------------
module tb_pwm_multi_channel;

   localparam int NUM_CH  = 16;
   localparam int CNT_W   = 8;
   localparam int PRESC_W = 4;
   localparam int CH_W    = $clog2(NUM_CH);
   localparam int MAXV    = (1 << CNT_W) - 1;

   localparam int NUM_CH2  = 5;
   localparam int CNT_W2   = 4;
   localparam int PRESC_W2 = 2;
   localparam int CH_W2    = $clog2(NUM_CH2);

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int checks = 0;
   int errors = 0;

   pwm_multi_channel_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) bus ();
   pwm_multi_channel_if #(.NUM_CH(NUM_CH2), .CNT_W(CNT_W2), .PRESC_W(PRESC_W2)) bus2 ();

   pwm_multi_channel #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   pwm_multi_channel #(.NUM_CH(NUM_CH2), .CNT_W(CNT_W2), .PRESC_W(PRESC_W2)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] actual,
                        input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural model: position inside the period, not counter + direction.
   // Edge period = MAXV+1 positions (cnt = pos); center period = 2*MAXV
   // positions (cnt rises 0..MAXV then falls MAXV-1..1).
   // ---------------------------------------------------------------------------
   int                m_presc = 0;
   int                m_pos   = 0;
   bit                m_mode  = 1'b0;
   int                m_pend [NUM_CH];
   int                m_act  [NUM_CH];
   logic [NUM_CH-1:0] exp_out = '0;
   logic              exp_ps  = 1'b0;

   function automatic int period_len(input bit mode);
      return mode ? 2 * MAXV : MAXV + 1;
   endfunction

   function automatic int cnt_of(input int pos, input bit mode);
      if (!mode || pos <= MAXV) return pos;
      return 2 * MAXV - pos;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_presc = 0;
         m_pos   = 0;
         m_mode  = 1'b0;
         exp_out = '0;
         exp_ps  = 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            m_pend[i] = 0;
            m_act[i]  = 0;
         end
      end else begin
         bit tick;
         bit bnd;
         int c;
         tick = (m_presc >= int'(bus.prescale));
         c    = cnt_of(m_pos, m_mode);
         for (int i = 0; i < NUM_CH; i++) begin
            exp_out[i] = bus.en_out[i] &&
                         (!bus.en_pwm[i] || m_act[i] == MAXV || c < m_act[i]);
         end
         bnd     = tick && (m_pos == period_len(m_mode) - 1);
         exp_ps  = bnd;
         m_presc = tick ? 0 : m_presc + 1;
         if (tick) m_pos = bnd ? 0 : m_pos + 1;
         if (bnd) begin
            for (int i = 0; i < NUM_CH; i++) m_act[i] = m_pend[i];
            m_mode = bus.center_mode;
         end
         if (bus.duty_wr_en && int'(bus.duty_wr_ch) < NUM_CH) begin
            m_pend[int'(bus.duty_wr_ch)] = int'(bus.duty_wr_data);
            if (bnd) m_act[int'(bus.duty_wr_ch)] = int'(bus.duty_wr_data);
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         check("cyc_out", 32'(bus.out), 32'(exp_out));
         check("cyc_period_start", 32'(bus.period_start), 32'(exp_ps));
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers (inputs change on the falling edge only)
   // ---------------------------------------------------------------------------
   int hi_cnt [NUM_CH];
   int hi2    [NUM_CH2];

   task automatic wr(input int ch, input int data);
      @(negedge clk);
      bus.duty_wr_en   = 1'b1;
      bus.duty_wr_ch   = CH_W'(ch);
      bus.duty_wr_data = CNT_W'(data);
      @(negedge clk);
      bus.duty_wr_en   = 1'b0;
   endtask

   task automatic wait_ps(input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.period_start && n < 8192);
      check({tag, "_ps_found"}, 32'(bus.period_start), 32'd1);
   endtask

   // Called on a period_start cycle; counts from there to the next one.
   // Window covers exactly one period because out lags cnt by one clk.
   // Optional ch0 writes are issued at cycle offsets w1_at / w2_at.
   task automatic measure(input string tag, input int w1_at, input int w1_data,
                          input int w2_at, input int w2_data, output int len);
      int n    = 0;
      bit seen = 1'b0;
      for (int i = 0; i < NUM_CH; i++) hi_cnt[i] = 0;
      while (!seen && n < 8192) begin
         bus.duty_wr_en = 1'b0;
         if (n == w1_at || n == w2_at) begin
            bus.duty_wr_en   = 1'b1;
            bus.duty_wr_ch   = '0;
            bus.duty_wr_data = CNT_W'((n == w1_at) ? w1_data : w2_data);
         end
         @(negedge clk);
         n++;
         for (int i = 0; i < NUM_CH; i++) if (bus.out[i]) hi_cnt[i]++;
         seen = bus.period_start;
      end
      bus.duty_wr_en = 1'b0;
      check({tag, "_ps_found"}, 32'(seen), 32'd1);
      len = n;
   endtask

   task automatic wr2(input int ch, input int data);
      @(negedge clk);
      bus2.duty_wr_en   = 1'b1;
      bus2.duty_wr_ch   = CH_W2'(ch);
      bus2.duty_wr_data = CNT_W2'(data);
      @(negedge clk);
      bus2.duty_wr_en   = 1'b0;
   endtask

   task automatic wait_ps2(input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus2.period_start && n < 256);
      check({tag, "_ps_found"}, 32'(bus2.period_start), 32'd1);
   endtask

   task automatic measure2(input string tag, output int len);
      int n    = 0;
      bit seen = 1'b0;
      for (int i = 0; i < NUM_CH2; i++) hi2[i] = 0;
      while (!seen && n < 256) begin
         @(negedge clk);
         n++;
         for (int i = 0; i < NUM_CH2; i++) if (bus2.out[i]) hi2[i]++;
         seen = bus2.period_start;
      end
      check({tag, "_ps_found"}, 32'(seen), 32'd1);
      len = n;
   endtask

   // ---------------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------------
   initial begin
      int len;
      int others;
      int sum [4];

      bus.en_out = '0;  bus.en_pwm = '0;  bus.duty_wr_en = 1'b0;
      bus.duty_wr_ch = '0;  bus.duty_wr_data = '0;
      bus.prescale = '0;  bus.center_mode = 1'b0;
      bus2.en_out = '1; bus2.en_pwm = '1; bus2.duty_wr_en = 1'b0;
      bus2.duty_wr_ch = '0; bus2.duty_wr_data = '0;
      bus2.prescale = '0; bus2.center_mode = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_out", 32'(bus.out), 32'd0);
      check("rst_period_start", 32'(bus.period_start), 32'd0);
      check("rst_out_dut2", 32'(bus2.out), 32'd0);
      #2 rst_n = 1'b1;

      // 1: ch0 duty 64, edge mode, prescale 0
      wr(0, 64);
      @(negedge clk);
      bus.en_out[0] = 1'b1;
      bus.en_pwm[0] = 1'b1;
      wait_ps("t1_align");
      measure("t1", -1, 0, -1, 0, len);
      check("t1_period_len", len, 256);
      check("t1_ch0_high", hi_cnt[0], 64);
      others = 0;
      for (int i = 1; i < NUM_CH; i++) others += hi_cnt[i];
      check("t1_others_high", others, 0);

      // 2: duty 0 / duty MAX / PWM disabled but output enabled
      wr(1, 0);
      wr(2, 255);
      @(negedge clk);
      bus.en_out[3:1] = 3'b111;
      bus.en_pwm[3:1] = 3'b011;
      wait_ps("t2_align");
      for (int i = 0; i < 4; i++) sum[i] = 0;
      for (int p = 0; p < 3; p++) begin
         measure("t2", -1, 0, -1, 0, len);
         check("t2_period_len", len, 256);
         for (int i = 0; i < 4; i++) sum[i] += hi_cnt[i];
      end
      check("t2_ch0_high", sum[0], 192);
      check("t2_ch1_duty0", sum[1], 0);
      check("t2_ch2_dutymax", sum[2], 768);
      check("t2_ch3_static", sum[3], 768);

      // 3: mid-period write, then write coinciding with a boundary
      measure("t3a", 100, 200, -1, 0, len);
      check("t3_old_period", hi_cnt[0], 64);
      measure("t3b", 50, 100, 255, 30, len);
      check("t3_new_period", hi_cnt[0], 200);
      measure("t3c", -1, 0, -1, 0, len);
      check("t3_boundary_write", hi_cnt[0], 30);

      // 4: prescale 3, duty 128
      bus.prescale = PRESC_W'(3);
      wr(0, 128);
      wait_ps("t4_align");
      measure("t4", -1, 0, -1, 0, len);
      check("t4_period_len", len, 1024);
      check("t4_ch0_high", hi_cnt[0], 512);
      // Lower prescale while the prescaler sits at 2.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (m_presc == 2) break;
      end
      bus.prescale = '0;
      wait_ps("t4b_align");
      measure("t4b", -1, 0, -1, 0, len);
      check("t4b_period_len", len, 256);
      check("t4b_ch0_high", hi_cnt[0], 128);

      // 5: center mode, duty 100. Per cycle high when cnt<100 on the way up
      // (0..99 = 100) and on the way down (99..1 = 99): 199 of 510.
      wr(0, 100);
      wait_ps("t5_align");
      measure("t5_edge", -1, 0, -1, 0, len);
      check("t5_edge_len", len, 256);
      check("t5_edge_high", hi_cnt[0], 100);
      bus.center_mode = 1'b1;
      measure("t5_switch", -1, 0, -1, 0, len);
      check("t5_switch_len", len, 256);
      check("t5_switch_high", hi_cnt[0], 100);
      for (int p = 0; p < 2; p++) begin
         measure("t5_center", -1, 0, -1, 0, len);
         check("t5_center_len", len, 510);
         check("t5_center_high", hi_cnt[0], 199);
      end
      bus.center_mode = 1'b0;
      measure("t5_back", -1, 0, -1, 0, len);
      check("t5_back_len", len, 510);
      measure("t5_edge2", -1, 0, -1, 0, len);
      check("t5_edge2_len", len, 256);
      check("t5_edge2_high", hi_cnt[0], 100);

      // Randomized traffic, checked cycle by cycle against the model.
      for (int n = 0; n < 6000; n++) begin
         int r;
         @(negedge clk);
         r = int'($urandom_range(0, 9));
         bus.duty_wr_en   = ($urandom_range(0, 3) == 0);
         bus.duty_wr_ch   = CH_W'($urandom_range(0, NUM_CH - 1));
         bus.duty_wr_data = (r == 0) ? '0 : (r == 1) ? '1 : CNT_W'($urandom);
         if ($urandom_range(0, 199) == 0) bus.prescale = PRESC_W'($urandom_range(0, 2));
         if ($urandom_range(0, 299) == 0) bus.center_mode = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 49) == 0) begin
            bus.en_out = NUM_CH'($urandom);
            bus.en_pwm = NUM_CH'($urandom);
         end
      end
      @(negedge clk);
      bus.duty_wr_en  = 1'b0;
      bus.prescale    = '0;
      bus.center_mode = 1'b0;
      bus.en_out      = 16'h000F;
      bus.en_pwm      = 16'h0007;

      // 6: asynchronous reset mid-period while out[0] is high
      wr(0, 128);
      wait_ps("t6_align");
      wait_ps("t6_align2");
      for (int i = 0; i < 600; i++) begin
         @(posedge clk);
         #1;
         if (bus.out[0]) break;
      end
      check("t6_pre_reset_out0", 32'(bus.out[0]), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("t6_async_out", 32'(bus.out), 32'd0);
      check("t6_async_period_start", 32'(bus.period_start), 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      wait_ps("t6_restart");
      measure("t6_after", -1, 0, -1, 0, len);
      check("t6_after_len", len, 256);
      check("t6_after_ch0", hi_cnt[0], 0);
      check("t6_after_ch1", hi_cnt[1], 0);
      check("t6_after_ch2", hi_cnt[2], 0);
      check("t6_after_ch3_static", hi_cnt[3], 256);

      // 6b: out-of-range write indices on the 5-channel instance
      wr2(5, 9);
      wr2(6, 3);
      wr2(7, 15);
      wait_ps2("t7_align");
      wait_ps2("t7_align2");
      measure2("t7", len);
      check("t7_period_len", len, 16);
      for (int i = 0; i < NUM_CH2; i++) check($sformatf("t7_ignored_ch%0d", i), hi2[i], 0);
      wr2(4, 5);
      wr2(0, 15);
      wait_ps2("t7b_align");
      measure2("t7b", len);
      check("t7b_period_len", len, 16);
      check("t7b_ch0_full", hi2[0], 16);
      check("t7b_ch1", hi2[1], 0);
      check("t7b_ch2", hi2[2], 0);
      check("t7b_ch3", hi2[3], 0);
      check("t7b_ch4", hi2[4], 5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      errors++;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
